inst_mem: RTL

Instruction memory that answers the core's fetch port: takes the byte address driven by the core, returns the addressed 32-bit instruction in the same cycle. It also contains a byte-serial program loader that fills the array word by word and holds the core in reset while a load is in progress. Sits beside the core top level, between the boot/debug byte source and the core's instruction fetch interface.

---
 rtl/inst_mem_pkg.sv | 15 +
 rtl/inst_mem_ram.sv | 25 ++
 rtl/inst_mem.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_pkg.sv
// Shared types and constants for the instruction memory and its byte-serial loader.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [31:0] INST_NOP          = 32'h0000_0013;
  localparam int          LD_BYTES_PER_WORD = 4;
  localparam int          LANE_W            = $clog2(LD_BYTES_PER_WORD);
  localparam int          LEN_W             = 16;

endpackage

// File: rtl/inst_mem_ram.sv
// Word-wide instruction array: one synchronous write port, one asynchronous read port.
module inst_mem_ram #(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_W      = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  // Contents deliberately survive reset so a partial reload keeps finished words.
  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_mem.sv
// Instruction fetch memory with a byte-serial program loader that holds the core in reset while loading.
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int ADDR_W      = 12,
  parameter bit BOOT_HOLD   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      inst_addr_i,
  output logic [31:0]      inst_o,
  input  logic             load_start_i,
  input  logic [LEN_W-1:0] load_len_i,
  input  logic             ld_valid_i,
  input  logic [7:0]       ld_data_i,
  output logic             ld_ready_o,
  output logic             load_busy_o,
  output logic             load_done_o,
  output logic             load_err_o,
  output logic             core_rst_n_o,
  output state_t           dbg_state
);

  // Loader handshake: a byte moves on a cycle where ld_valid_i && ld_ready_o;
  // ld_ready_o depends only on state, never on ld_valid_i.

  localparam logic [31:0]       DEPTH_U   = 32'(DEPTH_WORDS);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LD_BYTES_PER_WORD - 1);

  state_t              state;
  state_t              state_nxt;
  logic [LANE_W-1:0]   lane;
  logic [23:0]         asm_buf;
  logic [ADDR_W-1:0]   waddr;
  logic [LEN_W-1:0]    word_cnt;
  logic [LEN_W-1:0]    load_len;
  logic                core_rst_q;

  logic                start_zero;
  logic                start_bad;
  logic                start_ok;
  logic                byte_acc;
  logic                word_wr;
  logic                last_word;

  logic [ADDR_W-1:0]   raddr;
  logic [31:0]         ram_rdata;
  logic                addr_oob;
  logic                addr_lsb_unused;

  // ---------------------------------------------------------------------------
  // Start qualification and byte/word strobes
  // ---------------------------------------------------------------------------
  assign start_zero = (state == IDLE) && load_start_i && (load_len_i == '0);
  assign start_bad  = (state == IDLE) && load_start_i && (32'(load_len_i) > DEPTH_U);
  assign start_ok   = (state == IDLE) && load_start_i && !start_zero && !start_bad;

  assign byte_acc   = (state == LOAD) && ld_valid_i;
  assign word_wr    = byte_acc && (lane == LAST_LANE);
  assign last_word  = word_wr && (word_cnt == (load_len - LEN_W'(1)));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_ok) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        if (last_word) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ld_ready_o  = 1'b0;
    load_busy_o = 1'b0;
    load_done_o = 1'b0;
    load_err_o  = 1'b0;
    unique case (state)
      IDLE: begin
        load_done_o = start_zero;
        load_err_o  = start_bad;
      end
      LOAD: begin
        ld_ready_o  = 1'b1;
        load_busy_o = 1'b1;
      end
      DONE: begin
        load_done_o = 1'b1;
      end
      default: begin
        ld_ready_o  = 1'b0;
      end
    endcase
  end

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Assembly buffer, lane, word address and word count
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane     <= '0;
      asm_buf  <= '0;
      waddr    <= '0;
      word_cnt <= '0;
      load_len <= '0;
    end else if (start_ok) begin
      lane     <= '0;
      waddr    <= '0;
      word_cnt <= '0;
      load_len <= load_len_i;
    end else if (byte_acc) begin
      unique case (lane)
        2'd0:    asm_buf[7:0]   <= ld_data_i;
        2'd1:    asm_buf[15:8]  <= ld_data_i;
        2'd2:    asm_buf[23:16] <= ld_data_i;
        default: asm_buf        <= asm_buf;
      endcase
      if (word_wr) begin
        lane     <= '0;
        waddr    <= waddr + ADDR_W'(1);
        word_cnt <= word_cnt + LEN_W'(1);
      end else begin
        lane     <= lane + LANE_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Core reset control: low through a load, released on the edge leaving DONE
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_rst_q <= 1'b0;
    end else if (start_ok) begin
      core_rst_q <= 1'b0;
    end else if (state == DONE) begin
      core_rst_q <= 1'b1;
    end else if (!BOOT_HOLD && (state == IDLE)) begin
      core_rst_q <= 1'b1;
    end
  end

  assign core_rst_n_o = core_rst_q;

  // ---------------------------------------------------------------------------
  // Fetch read path
  // ---------------------------------------------------------------------------
  assign raddr           = inst_addr_i[ADDR_W+1:2];
  assign addr_oob        = |inst_addr_i[31:ADDR_W+2];
  assign addr_lsb_unused = ^inst_addr_i[1:0];
  assign inst_o          = addr_oob ? INST_NOP : ram_rdata;

  inst_mem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (word_wr),
    .waddr (waddr),
    .wdata ({ld_data_i, asm_buf}),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

endmodule
